// File: rtl/core_mem_bridge_if.sv
// Bus bundle between the host loader / multicycle core and core_mem_bridge.
// The requesters use the master modport; the bridge uses the slave modport.
interface core_mem_bridge_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              core_select;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              host_ack;

    logic              core_mem_en;
    logic              core_mem_write;
    logic              core_mem_read;
    logic [ADDR_W-1:0] core_mem_addr;
    logic [DATA_W-1:0] core_mem_data_in;
    logic [DATA_W-1:0] core_mem_data_out;
    logic              core_eoc;
    logic              core_start;

    logic              bus_err;

    modport master (
        output core_select,
        output host_req, host_we, host_addr, host_wdata,
        input  host_rdata, host_ack,
        output core_mem_en, core_mem_write, core_mem_read, core_mem_addr, core_mem_data_in,
        input  core_mem_data_out, core_eoc, core_start,
        input  bus_err
    );

    modport slave (
        input  core_select,
        input  host_req, host_we, host_addr, host_wdata,
        output host_rdata, host_ack,
        input  core_mem_en, core_mem_write, core_mem_read, core_mem_addr, core_mem_data_in,
        output core_mem_data_out, core_eoc, core_start,
        output bus_err
    );
endinterface

// File: rtl/core_mem_bridge.sv
// Single-port RAM bridge shared by the host loader and the multicycle core (IDLE -> ACC -> DONE).
// Define CORE_MEM_ERR_EN to build the sticky bus_err flag for non-owner requests.
module core_mem_bridge #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    core_mem_bridge_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;

    logic              owner_q;
    logic              core_rq;
    logic              host_rq;
    logic              accept;
    logic              host_ack;
    logic              core_eoc;
    logic              core_start_q;

    // Fields latched when a request is accepted; the requester may drop them afterwards.
    logic              sel_core_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [DATA_W-1:0] ram [0:(1 << ADDR_W) - 1];
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] host_rdata_q;
    logic [DATA_W-1:0] core_rdata_q;

    assign core_rq = bus.core_mem_en & (bus.core_mem_write | bus.core_mem_read);
    assign host_rq = bus.host_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Requests in IDLE are judged against the owner being loaded on this same edge.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        host_ack = 1'b0;
        core_eoc = 1'b0;
        case (state_q)
            IDLE: begin
                accept = bus.core_select ? core_rq : host_rq;
                if (accept) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                state_d = DONE;
            end
            DONE: begin
                core_eoc = sel_core_q;
                host_ack = ~sel_core_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= 1'b0;
            core_start_q <= 1'b0;
        end else begin
            core_start_q <= (state_q == IDLE) & bus.core_select & ~owner_q;
            if (state_q == IDLE) begin
                owner_q <= bus.core_select;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_core_q <= 1'b0;
            we_q       <= 1'b0;
        end else if (accept) begin
            sel_core_q <= bus.core_select;
            we_q       <= bus.core_select ? bus.core_mem_write : bus.host_we;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.core_select ? bus.core_mem_addr    : bus.host_addr;
            wdata_q <= bus.core_select ? bus.core_mem_data_in : bus.host_wdata;
        end
    end

    // ---- ACC stage: single RAM operation on the captured fields ----
    always_ff @(posedge clk) begin
        if ((state_q == ACC) && we_q) begin
            ram[addr_q] <= wdata_q;
        end
    end

    assign rd_word = ram[addr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rdata_q <= '0;
            core_rdata_q <= '0;
        end else if ((state_q == ACC) && !we_q) begin
            if (sel_core_q) begin
                core_rdata_q <= rd_word;
            end else begin
                host_rdata_q <= rd_word;
            end
        end
    end

`ifdef CORE_MEM_ERR_EN
    logic err_hit;
    logic bus_err_q;

    assign err_hit = (state_q == IDLE) & (bus.core_select ? host_rq : core_rq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err_q <= 1'b0;
        end else if (err_hit) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus.bus_err = bus_err_q;
`else
    assign bus.bus_err = 1'b0;
`endif

    assign bus.host_rdata        = host_rdata_q;
    assign bus.host_ack          = host_ack;
    assign bus.core_mem_data_out = core_rdata_q;
    assign bus.core_eoc          = core_eoc;
    assign bus.core_start        = core_start_q;

endmodule
